ins_loader: RTL
===============

INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction memory capacity in 32-bit words; legal word addresses are 0..DEPTH-1.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: load_start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-005 Port: in_valid  input  1  byte-stream valid.
REQ-006 Port: in_data  input  8  byte-stream payload, big-endian.
REQ-007 Port: in_ready  output  1  loader accepts a byte; a byte transfers on a clk edge with in_valid and in_ready both high.
REQ-008 Port: wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: wr_addr  output  32  word address, the same unit as the CPU PC (PC+1 = next instruction).
REQ-010 Port: wr_data  output  32  assembled instruction word.
REQ-011 Port: cpu_run  output  1  releases the CPU; low holds the CPU PC at 0.
REQ-012 Port: busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-013 Port: err  output  1  high in ERROR.

Function
REQ-014 The stream format SHALL be: length high byte, length low byte (N = number of words, 16-bit), then N words of 4 bytes each, MSB first.
REQ-015 The FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE and ERROR.
REQ-016 Transitions: IDLE/DONE/ERROR -> LEN_HI on load_start; LEN_HI -> LEN_LO on a byte; LEN_LO -> DATA on a byte.
REQ-017 Bounds check at LEN_LO: N > DEPTH -> ERROR; N = 0 -> CSUM if checksum is enabled, else DONE.
REQ-018 DATA SHALL assemble bytes with a 2-bit byte counter; on the 4th byte the word is complete and the byte counter wraps to 0.
REQ-019 wr_en SHALL be high exactly in the cycle after the 4th byte handshake of a word, with wr_addr = word index (0..N-1) and wr_data = the assembled word.
REQ-020 After word N-1 is written, DATA -> CSUM if checksum is enabled, else DONE.
REQ-021 in_ready SHALL be high only in LEN_HI, LEN_LO, DATA and CSUM; bytes presented in other states SHALL be ignored.
REQ-022 in_valid low SHALL stall the FSM with no state change, for any number of cycles.
REQ-023 cpu_run SHALL be high only in DONE; it falls in the cycle the loader leaves DONE.
REQ-024 load_start during busy SHALL be ignored.

Reset
REQ-025 On rst the block SHALL immediately enter IDLE, independent of clk.
REQ-026 Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_run=0, busy=0, err=0, byte counter=0, word counter=0.
REQ-027 rst asserted mid-load SHALL abort the load; already-written words stay in memory and no further writes occur.

Configuration
REQ-028 With LOADER_CHECKSUM_EN defined, one trailing byte SHALL follow the payload in state CSUM; it must equal the XOR of all payload bytes (length bytes excluded). Match -> DONE, mismatch -> ERROR.
REQ-029 Without LOADER_CHECKSUM_EN, CSUM is unreachable, no trailing byte is consumed, and the checksum register is absent.

Structure
REQ-030 Package ins_loader_pkg SHALL hold the state enumeration, the length-header byte count (2) and the bytes-per-word constant (4).
REQ-031 One sub-module, byte_packer, SHALL hold the byte counter and the 32-bit shift register, and SHALL output a word-complete pulse.

Verification
REQ-032 Scenario: N=2 with words 0x20010005 and 0xAC010000, in_valid held high -> two wr_en pulses at addr 0 and addr 1 with those data, then cpu_run=1.
REQ-033 Scenario: same stream with in_valid toggled every other cycle -> identical writes, and the FSM never advances on an in_valid=0 cycle.
REQ-034 Scenario: N=DEPTH+1 -> err=1 after the LEN_LO byte, zero wr_en pulses, cpu_run=0.
REQ-035 Scenario: N=0 -> DONE (or CSUM expecting byte 0x00 when LOADER_CHECKSUM_EN is defined) with no writes.
REQ-036 Scenario: rst pulsed after the 6th byte of an N=3 load -> IDLE, all outputs 0; a fresh load_start then a full load succeeds.
REQ-037 Scenario (LOADER_CHECKSUM_EN): payload 0x01 0x02 0x03 0x04 with checksum 0x04 -> DONE; with checksum 0x05 -> ERROR, err=1, cpu_run=0.

Source files
------------

// File: rtl/ins_loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : ins_loader_pkg
// Description : Shared constants for the instruction loader: FSM state codes,
//               length-header size and bytes per instruction word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ins_loader_pkg;

  // Stream framing
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Loader FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

endpackage

`default_nettype wire

// File: rtl/ins_loader_if.sv
//------------------------------------------------------------------------------
// Module      : ins_loader_if
// Description : Byte-stream input, instruction-memory write port and status
//               outputs of the instruction loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ins_loader_if;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_run;
  logic        busy;
  logic        err;

  // Host / environment side
  modport master (
    output load_start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_run, busy, err
  );

  // Loader side
  modport slave (
    input  load_start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_run, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/ins_loader_byte_packer.sv
//------------------------------------------------------------------------------
// Module      : byte_packer
// Description : Shifts big-endian bytes into a 32-bit word and pulses
//               o_wordDone for one cycle after the 4th byte of each word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_packer
  import ins_loader_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_clr,
  input  wire logic        i_accept,
  input  wire logic [7:0]  i_dataIn,
  output logic      [1:0]  o_byteCnt,
  output logic      [31:0] o_word,
  output logic             o_wordDone
);

  localparam logic [1:0] c_lastByte = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byteCnt;
  logic [31:0] r_shift;
  logic        r_wordDone;

  // Shift bytes in MSB first; counter wraps naturally after the 4th byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byteCnt  <= 2'd0;
      r_shift    <= 32'd0;
      r_wordDone <= 1'b0;
    end else begin
      r_wordDone <= 1'b0;
      if (i_clr) begin
        r_byteCnt <= 2'd0;
        r_shift   <= 32'd0;
      end else if (i_accept) begin
        r_shift    <= {r_shift[23:0], i_dataIn};
        r_byteCnt  <= r_byteCnt + 2'd1;
        r_wordDone <= (r_byteCnt == c_lastByte);
      end
    end
  end

  assign o_byteCnt  = r_byteCnt;
  assign o_word     = r_shift;
  assign o_wordDone = r_wordDone;

endmodule

`default_nettype wire

// File: rtl/ins_loader.sv
//------------------------------------------------------------------------------
// Module      : ins_loader
// Description : Loads a length-prefixed big-endian byte stream into
//               instruction memory, then releases the CPU.
//               Optional macro LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum byte verified in state CSUM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  wire logic    clk,
  input  wire logic    rst,
  ins_loader_if.slave  bus
);

  localparam logic [1:0] c_lastByte = 2'(BYTES_PER_WORD - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] c_afterData = S_CSUM;
`else
  localparam logic [2:0] c_afterData = S_DONE;
`endif

  logic [2:0]  r_state;
  logic [7:0]  r_lenHi;
  logic [15:0] r_numWords;
  logic [15:0] r_wordCnt;
  logic        r_lastPending;

  logic        w_ready;
  logic        w_xfer;
  logic        w_start;
  logic        w_accept;
  logic        w_lastByte;
  logic [15:0] w_len;
  logic [1:0]  w_byteCnt;
  logic [31:0] w_word;
  logic        w_wordDone;

  // Byte acceptance; held off during the final word's write cycle so a
  // trailing byte is never mistaken for payload
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_CSUM: w_ready = 1'b1;
      S_DATA:                     w_ready = !r_lastPending;
      default:                    w_ready = 1'b0;
    endcase
  end

  assign w_xfer     = bus.in_valid && w_ready;
  assign w_start    = bus.load_start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_accept   = w_xfer && (r_state == S_DATA);
  assign w_len      = {r_lenHi, bus.in_data};
  assign w_lastByte = w_accept && (w_byteCnt == c_lastByte) &&
                      (r_wordCnt == r_numWords - 16'd1);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start),
    .i_accept   (w_accept),
    .i_dataIn   (bus.in_data),
    .o_byteCnt  (w_byteCnt),
    .o_word     (w_word),
    .o_wordDone (w_wordDone)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running XOR of payload bytes, restarted with each load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_csum <= 8'd0;
    else if (w_start)  r_csum <= 8'd0;
    else if (w_accept) r_csum <= r_csum ^ bus.in_data;
  end
`endif

  // Loader FSM with length capture and word index tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lenHi       <= 8'd0;
      r_numWords    <= 16'd0;
      r_wordCnt     <= 16'd0;
      r_lastPending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_start) begin
            r_state       <= S_LEN_HI;
            r_wordCnt     <= 16'd0;
            r_lastPending <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_lenHi <= bus.in_data;
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_numWords <= w_len;
            if (32'(w_len) > DEPTH)  r_state <= S_ERROR;
            else if (w_len == 16'd0) r_state <= c_afterData;
            else                     r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_lastByte) r_lastPending <= 1'b1;
          if (w_wordDone) begin
            r_wordCnt <= r_wordCnt + 16'd1;
            if (r_lastPending) begin
              r_lastPending <= 1'b0;
              r_state       <= c_afterData;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) r_state <= (bus.in_data == r_csum) ? S_DONE : S_ERROR;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = w_wordDone;
  assign bus.wr_addr  = 32'(r_wordCnt);
  assign bus.wr_data  = w_word;
  assign bus.cpu_run  = (r_state == S_DONE);
  assign bus.err      = (r_state == S_ERROR);
  assign bus.busy     = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

endmodule

`default_nettype wire
